// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and widths for the multiplier result serializer
package mult_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int PROD_W = 38;
  localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/mult_result_holdbuf.sv
// mult_result_holdbuf: one-entry holding register that parks a product while a frame is shifting
module mult_result_holdbuf
  import mult_pkg::*;
#(
  parameter int WIDTH = PROD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) dout <= din;
      full <= wr_en | (full & ~rd_en);
    end
  end
endmodule

// File: rtl/mult_result_serializer.sv
// mult_result_serializer: shifts multiplier products out one bit per s_en, one product buffered, overflow counted
module mult_result_serializer
  import mult_pkg::*;
#(
  parameter int WIDTH     = PROD_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      z,
  input  logic                  z_valid,
  output logic                  z_ready,
  input  logic                  s_en,
  output logic                  sdata,
  output logic                  sframe,
  output logic                  slast,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, buf_q, shifted;
  logic [CW-1:0] cnt, cnt_nx;
  logic buf_full, drain, buf_wr, buf_rd;
  assign sframe  = state == SHIFT;
  assign sdata   = sframe & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign slast   = sframe & (cnt == CW'(WIDTH-1));
  assign drain   = slast & s_en;
  assign z_ready = ~sframe | ~buf_full | drain;
  // in IDLE the product goes straight to the shift register, never the buffer
  assign buf_wr  = sframe & z_valid & z_ready;
  assign buf_rd  = drain & buf_full;
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  mult_result_holdbuf #(.WIDTH(WIDTH)) u_holdbuf (
    .clk   (clk),
    .reset (reset),
    .wr_en (buf_wr),
    .rd_en (buf_rd),
    .din   (z),
    .dout  (buf_q),
    .full  (buf_full)
  );
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    if (!sframe) begin
      state_nx = z_valid ? SHIFT : IDLE;
      shreg_nx = z_valid ? z : shreg;
      cnt_nx   = '0;
    end else if (drain) begin
      state_nx = buf_full ? SHIFT : IDLE;
      shreg_nx = buf_full ? buf_q : '0;
      cnt_nx   = '0;
    end else if (s_en) begin
      shreg_nx = shifted;
      cnt_nx   = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) drop_cnt <= '0;
    else if (z_valid & ~z_ready & (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
  end
endmodule

// File: tb/tb_mult_result_serializer.sv
// tb_mult_result_serializer: directed checks of framing, buffering, overflow, stall, reset and bit order
module tb_mult_result_serializer;
  localparam int W = 38;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] z = '0;
  logic z_valid = 1'b0;
  logic s_en = 1'b1;
  logic z_ready, sdata, sframe, slast;
  logic [7:0] drop_cnt;
  logic z_ready2, sdata2, sframe2, slast2;
  logic [7:0] drop_cnt2;
  int checks = 0;
  int errors = 0;
  logic [127:0] bits;
  int len, l1, l2;
  logic r0, r1;

  always #5 clk = ~clk;

  mult_result_serializer dut (
    .clk(clk), .reset(reset), .z(z), .z_valid(z_valid), .z_ready(z_ready),
    .s_en(s_en), .sdata(sdata), .sframe(sframe), .slast(slast), .drop_cnt(drop_cnt)
  );

  mult_result_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .z(z), .z_valid(z_valid), .z_ready(z_ready2),
    .s_en(s_en), .sdata(sdata2), .sframe(sframe2), .slast(slast2), .drop_cnt(drop_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records every sframe cycle of dut until it drops (bounded), optionally presenting
  // up to two extra products on the first collected cycles.
  task automatic collect(input int n_inj, input logic [W-1:0] v0, input logic [W-1:0] v1,
                         output logic [127:0] b, output int n, output int a1, output int a2,
                         output logic rd0, output logic rd1);
    b = '0; n = 0; a1 = -1; a2 = -1; rd0 = 1'bx; rd1 = 1'bx;
    while (sframe && n < 200) begin
      z_valid = n < n_inj;
      z = n == 0 ? v0 : v1;
      #1;
      if (n == 0) rd0 = z_ready;
      if (n == 1) rd1 = z_ready;
      b[n] = sdata;
      if (slast) begin
        if (a1 < 0) a1 = n;
        else a2 = n;
      end
      n++;
      tick();
    end
    z_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_sframe", sframe, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_slast", slast, 0);
    chk("rst_z_ready", z_ready, 1);
    chk("rst_drop_cnt", drop_cnt, 0);

    // single word
    z = 38'h0000000005; z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    chk("single_first_bit", sdata, 1);
    collect(0, '0, '0, bits, len, l1, l2, r0, r1);
    chk("single_len", len, 38);
    chk("single_data", bits, 128'h5);
    chk("single_slast_pos", l1, 37);
    chk("single_one_slast", l2, -1);
    chk("single_idle", sframe, 0);
    chk("single_idle_ready", z_ready, 1);

    // back-to-back: second product buffered, no gap
    z = 38'h1; z_valid = 1'b1;
    tick();
    collect(1, 38'h2, '0, bits, len, l1, l2, r0, r1);
    chk("b2b_ready", r0, 1);
    chk("b2b_len", len, 76);
    chk("b2b_data", bits, {52'h0, 38'h2, 38'h1});
    chk("b2b_slast1", l1, 37);
    chk("b2b_slast2", l2, 75);
    chk("b2b_drop", drop_cnt, 0);

    // overflow: third consecutive product dropped
    z = 38'h123456789A; z_valid = 1'b1;
    tick();
    collect(2, 38'h30F0F0F0F0, 38'h0000FFFFFF, bits, len, l1, l2, r0, r1);
    chk("ovf_ready_2nd", r0, 1);
    chk("ovf_ready_3rd", r1, 0);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_len", len, 76);
    chk("ovf_data", bits, {52'h0, 38'h30F0F0F0F0, 38'h123456789A});

    // stall at bit 10
    z = 38'h0000000401; z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_bit10", sdata, 1);
    s_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_hold_sdata", sdata, 1);
    chk("stall_hold_frame", sframe, 1);
    chk("stall_hold_slast", slast, 0);
    s_en = 1'b1;
    collect(0, '0, '0, bits, len, l1, l2, r0, r1);
    chk("stall_rest_len", len, 28);
    chk("stall_rest_data", bits, 128'h1);
    chk("stall_rest_slast", l1, 27);

    // saturation then mid-frame reset
    s_en = 1'b0;
    z = 38'h3FFFFFFFFF; z_valid = 1'b1;
    tick();
    z = 38'h2AAAAAAAAA;
    tick();
    for (int i = 0; i < 300; i++) tick();
    chk("sat_drop", drop_cnt, 255);
    chk("sat_ready", z_ready, 0);
    z_valid = 1'b0;
    s_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_mid_frame", {sframe, slast, sdata}, 3'b101);
    reset = 1'b1;
    tick();
    chk("midrst_sframe", sframe, 0);
    chk("midrst_sdata", sdata, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_ready", z_ready, 1);
    reset = 1'b0;
    z = 38'h0000000003; z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    collect(0, '0, '0, bits, len, l1, l2, r0, r1);
    chk("midrst_buf_cleared_len", len, 38);
    chk("midrst_new_data", bits, 128'h3);

    // MSB-first ordering
    z = 38'h2000000000; z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    bits = '0;
    for (int i = 0; i < 38; i++) begin
      bits[i] = sdata2;
      if (i == 0) chk("msb_frame", sframe2, 1);
      tick();
    end
    chk("msb_first_bit_only", bits, 128'h1);
    chk("msb_idle", sframe2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_result_serializer.md
MULT_RESULT_SERIALIZER -- requirements
Module: mult_result_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 38, giving the product width taken from the DSP multiplier output.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0, where 0 means LSB-first serial order and 1 means MSB-first.
REQ-003 The block SHALL have port clk, input, 1 bit, clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, reset (synchronous, active-high).
REQ-005 The block SHALL have port z, input, WIDTH bits, unregistered unsigned product from the multiplier.
REQ-006 The block SHALL have port z_valid, input, 1 bit, which qualifies z for one cycle.
REQ-007 The block SHALL have port z_ready, output, 1 bit, high when a product presented this cycle will be accepted.
REQ-008 The block SHALL have port s_en, input, 1 bit, downstream advance; one serial bit is consumed per cycle in which it is high.
REQ-009 The block SHALL have port sdata, output, 1 bit, current serial bit.
REQ-010 The block SHALL have port sframe, output, 1 bit, high while a word is being shifted out.
REQ-011 The block SHALL have port slast, output, 1 bit, high while the final bit of a word is on sdata.
REQ-012 The block SHALL have port drop_cnt, output, 8 bits, saturating count of products lost to overflow.

Function
REQ-013 The block SHALL implement states IDLE and SHIFT, plus a one-entry hold buffer with a buf_full flag.
REQ-014 In IDLE with z_valid=1, the block SHALL load z into the shift register, clear the bit counter, and enter SHIFT; from the next cycle sframe=1 and sdata=z[0] (z[WIDTH-1] if MSB_FIRST=1).
REQ-015 In SHIFT, the block SHALL advance sdata to the next bit and increment the counter on each cycle with s_en=1.
REQ-016 In SHIFT with s_en=0, the block SHALL hold sdata, the counter, and all outputs unchanged.
REQ-017 slast SHALL equal sframe AND (counter == WIDTH-1).
REQ-018 drain SHALL be defined as slast AND s_en.
REQ-019 On drain with buf_full=1, the block SHALL move the buffer into the shift register, clear the counter, and stay in SHIFT, so sframe stays high with no gap cycle.
REQ-020 On drain with buf_full=0, the block SHALL enter IDLE.
REQ-021 In SHIFT, a product SHALL be accepted when z_valid AND (NOT buf_full OR drain).
REQ-022 An accepted product in SHIFT SHALL be written to the buffer, and buf_full SHALL be 1 the next cycle.
REQ-023 When drain occurs on the same cycle a product is accepted, the old buffer content SHALL go to the shift register and the new product SHALL go to the buffer.
REQ-024 z_ready SHALL be the combinational value (state==IDLE) OR NOT buf_full OR drain.
REQ-025 A product presented with z_valid=1 and z_ready=0 SHALL be dropped, and drop_cnt SHALL increment by 1, saturating at 255.
REQ-026 Invariant: buf_full SHALL be 0 whenever the state is IDLE.
REQ-027 When sframe=0, sdata SHALL be 0.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL go to IDLE with buf_full=0, shift register 0, counter 0, and drop_cnt=0.
REQ-029 After reset, sdata=0, sframe=0, slast=0, and z_ready=1.
REQ-030 Reset SHALL take priority over z_valid and s_en.
REQ-031 Reset mid-frame SHALL abort the frame, with sframe low from the next cycle and no partial-word completion.

Structure
REQ-032 A shared package mult_pkg SHALL hold the state enum (IDLE, SHIFT), the PROD_W=38 constant, and the DROP_CNT_W=8 constant.
REQ-033 The hold buffer SHALL be one sub-module, mult_result_holdbuf, with WIDTH data, a write-enable, a read-enable, and a full flag.
REQ-034 The FSM, shift register, and counter SHALL live in the top module, with counter width $clog2(WIDTH).

Verification
REQ-035 Single word: reset, then z=38'h0000000005 with z_valid for 1 cycle and s_en=1 -> sframe high for 38 cycles, sdata sequence 1,0,1,0,0...0, slast on the 38th cycle, then IDLE.
REQ-036 Back-to-back: z=38'h1 then z=38'h2 presented one cycle apart, s_en=1 -> the second is buffered, 76 contiguous sframe cycles, slast pulses at cycles 38 and 76, drop_cnt=0.
REQ-037 Overflow: three z_valid pulses on consecutive cycles during a frame -> first shifted, second buffered, third dropped with z_ready=0, drop_cnt=1.
REQ-038 Stall: s_en=0 for 5 cycles at bit 10 -> sdata and counter frozen, with the frame completing 5 cycles late and unchanged data.
REQ-039 Saturation and reset: 300 drops -> drop_cnt=255; then reset asserted at bit 20 -> next cycle sframe=0, drop_cnt=0, z_ready=1.
REQ-040 MSB_FIRST=1 with z=38'h2000000000 -> first sdata bit is 1 and the remaining 37 bits are 0.
